// File: rtl/ddr_axi_rd_master_pkg.sv
// Shared configuration and constants for the DDR ring read/write masters.
// Both masters must agree on the ring geometry, so it lives here.
package ddr_axi_rd_master_pkg;

  localparam int          CFG_DATA_WIDTH  = 128;
  localparam int          CFG_ADDR_WIDTH  = 32;
  localparam int          CFG_BURST_LEN   = 16;
  localparam logic [31:0] CFG_BASE_ADDR   = 32'h0000_0000;
  localparam int          CFG_RING_BURSTS = 4096;
  localparam int          CFG_HOLDOFF     = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } rd_state_e;

  // AxSIZE encoding for a beat of the given byte width
  function automatic logic [2:0] axi_size_f(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/ddr_axi_rd_master_if.sv
// AXI4 read-address and read-data channels between the read master and DDR.
interface ddr_axi_rd_master_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic [7:0]        M_AXI_ARLEN;
  logic [2:0]        M_AXI_ARSIZE;
  logic [1:0]        M_AXI_ARBURST;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;
  logic [DATA_W-1:0] M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              M_AXI_RLAST;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;

  modport master (
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  M_AXI_RREADY
  );

endinterface

// File: rtl/ddr_ring_occupancy.sv
// Up/down burst counter for the DDR ring. Saturates at RING_BURSTS and
// raises a sticky overflow flag if an increment arrives while full.
module ddr_ring_occupancy
  import ddr_axi_rd_master_pkg::*;
#(
  parameter int RING_BURSTS = CFG_RING_BURSTS,
  parameter int CNT_W       = $clog2(RING_BURSTS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  // Next count: simultaneous inc/dec cancel; inc at full saturates and flags
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    case ({inc, dec})
      2'b10: begin
        if (count_q == CNT_W'(RING_BURSTS)) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      2'b01: begin
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          count_d = count_q;
        end
      end
      default: count_d = count_q;
    endcase
  end

  // Occupancy state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/ddr_axi_rd_master.sv
// AXI4 read master feeding the DDR read FIFO from a ring of fixed-length
// INCR bursts. One burst outstanding at a time; a holdoff gap after each
// burst lets the FIFO's synchronised refill request settle.
module ddr_axi_rd_master
  import ddr_axi_rd_master_pkg::*;
#(
  parameter int                            C_M_AXI_DATA_WIDTH = CFG_DATA_WIDTH,
  parameter int                            C_M_AXI_ADDR_WIDTH = CFG_ADDR_WIDTH,
  parameter int                            BURST_LEN          = CFG_BURST_LEN,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = CFG_BASE_ADDR,
  parameter int                            RING_BURSTS        = CFG_RING_BURSTS,
  parameter int                            HOLDOFF            = CFG_HOLDOFF,
  parameter int                            AVAIL_W            = $clog2(RING_BURSTS + 1)
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          ddr_rd_en,
  input  logic                          wr_burst_done,
  input  logic                          fifo_full,
  ddr_axi_rd_master_if.master           m_axi,
  output logic [C_M_AXI_DATA_WIDTH-1:0] fifo_din,
  output logic                          fifo_wr_en,
  output logic [AVAIL_W-1:0]            avail_bursts,
  output logic [3:0]                    err_flags
);

  localparam int AW     = C_M_AXI_ADDR_WIDTH;
  localparam int DW     = C_M_AXI_DATA_WIDTH;
  localparam int IDX_W  = (RING_BURSTS > 1) ? $clog2(RING_BURSTS) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  // HOLDOFF is expected to be at least 1
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [AW-1:0] BURST_BYTES = AW'(BURST_LEN * (DW / 8));

  rd_state_e         state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic [AW-1:0]     araddr_q, araddr_d;
  logic              rready_q, rready_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DW-1:0]     fifo_din_q, fifo_din_d;
  logic              fifo_wr_en_q, fifo_wr_en_d;
  logic [2:0]        err_q, err_d;

  logic               ar_hs_s;
  logic               r_hs_s;
  logic               last_beat_s;
  logic               occ_ovf_s;
  logic [AVAIL_W-1:0] avail_s;

  assign ar_hs_s     = arvalid_q & m_axi.M_AXI_ARREADY;
  assign r_hs_s      = rready_q & m_axi.M_AXI_RVALID;
  assign last_beat_s = (beat_q == BEAT_W'(BURST_LEN - 1));

  ddr_ring_occupancy #(
    .RING_BURSTS (RING_BURSTS),
    .CNT_W       (AVAIL_W)
  ) u_occ (
    .clk   (M_AXI_ACLK),
    .rst_n (M_AXI_ARESETN),
    .inc   (wr_burst_done),
    .dec   (ar_hs_s),
    .count (avail_s),
    .ovf   (occ_ovf_s)
  );

  // Burst sequencing: request decision, address phase, beat collection, holdoff
  always_comb begin
    state_d      = state_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    rready_d     = rready_q;
    idx_d        = idx_q;
    beat_d       = beat_q;
    hold_d       = hold_q;
    fifo_din_d   = fifo_din_q;
    fifo_wr_en_d = 1'b0;
    err_d        = err_q;
    // Writing into a full FIFO loses data; RREADY is deliberately not throttled
    err_d[2]     = err_q[2] | (fifo_wr_en_q & fifo_full);

    case (state_q)
      ST_IDLE: begin
        if (ddr_rd_en && (avail_s != '0)) begin
          state_d   = ST_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = BASE_ADDR + (AW'(idx_q) * BURST_BYTES);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (ar_hs_s) begin
          state_d   = ST_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_d    = '0;
          if (idx_q == IDX_W'(RING_BURSTS - 1)) begin
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (r_hs_s) begin
          fifo_din_d   = m_axi.M_AXI_RDATA;
          fifo_wr_en_d = 1'b1;
          err_d[0]     = err_q[0] | (m_axi.M_AXI_RRESP != AXI_RESP_OKAY);
          err_d[1]     = err_q[1] | (m_axi.M_AXI_RLAST != last_beat_s);
          // The burst always ends on the beat count, whatever RLAST says
          if (last_beat_s) begin
            state_d  = ST_HOLD;
            rready_d = 1'b0;
            beat_d   = '0;
            hold_d   = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_W'(HOLDOFF - 1)) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q      <= ST_IDLE;
      arvalid_q    <= 1'b0;
      araddr_q     <= BASE_ADDR;
      rready_q     <= 1'b0;
      idx_q        <= '0;
      beat_q       <= '0;
      hold_q       <= '0;
      fifo_din_q   <= '0;
      fifo_wr_en_q <= 1'b0;
      err_q        <= 3'b000;
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rready_q     <= rready_d;
      idx_q        <= idx_d;
      beat_q       <= beat_d;
      hold_q       <= hold_d;
      fifo_din_q   <= fifo_din_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      err_q        <= err_d;
    end
  end

  assign m_axi.M_AXI_ARADDR  = araddr_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_ARLEN   = 8'(BURST_LEN - 1);
  assign m_axi.M_AXI_ARSIZE  = axi_size_f(DW / 8);
  assign m_axi.M_AXI_ARBURST = AXI_BURST_INCR;
  assign m_axi.M_AXI_RREADY  = rready_q;

  assign fifo_din     = fifo_din_q;
  assign fifo_wr_en   = fifo_wr_en_q;
  assign avail_bursts = avail_s;
  assign err_flags    = {occ_ovf_s, err_q};

endmodule
